// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - memory-mapped 16-bit down-counting timer with prescaler, snapshot read and IRQ
module bus_timer #(
  parameter logic [15:0] BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AD,
  input  logic [7:0]  DO,
  input  logic        WE,
  input  logic        RDY,
  output logic [7:0]  DI,
  output logic        hit,
  output logic        IRQ
);

  logic        sel;
  logic [2:0]  offset;
  logic        wr;
  logic        tick;
  logic        expire;
  logic [7:0]  rd_data;

  logic [15:0] latch;
  logic [15:0] counter;
  logic [7:0]  pre;
  logic [7:0]  prescaler;
  logic        en;
  logic        cont;
  logic        ie;
  logic        tf;
  logic [7:0]  snap;

  assign sel    = (AD[15:3] == BASE[15:3]);
  assign offset = AD[2:0];
  assign wr     = sel && WE && RDY;
  assign tick   = en && (prescaler == 8'd0);
  assign expire = tick && (counter == 16'd0);

  always_comb begin
    rd_data = 8'h00;
    case (offset)
      3'd0:    rd_data = counter[7:0];
      3'd1:    rd_data = snap;
      3'd2:    rd_data = {5'b00000, ie, cont, en};
      3'd3:    rd_data = {7'b0000000, tf};
      3'd4:    rd_data = pre;
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      latch     <= 16'hFFFF;
      counter   <= 16'hFFFF;
      pre       <= 8'h00;
      prescaler <= 8'h00;
      en        <= 1'b0;
      cont      <= 1'b0;
      ie        <= 1'b0;
      tf        <= 1'b0;
      snap      <= 8'h00;
      DI        <= 8'h00;
      hit       <= 1'b0;
      IRQ       <= 1'b0;
    end else begin
      DI  <= sel ? rd_data : 8'h00;
      hit <= sel;
      IRQ <= tf && ie;

      // Capturing the high byte on the low-byte read makes a low-then-high read coherent
      if (sel && (offset == 3'd0) && !WE)
        snap <= counter[15:8];

      if (en) begin
        if (prescaler == 8'd0)
          prescaler <= pre;
        else
          prescaler <= prescaler - 8'd1;
      end

      if (tick) begin
        if (counter == 16'd0) begin
          tf <= 1'b1;
          if (cont)
            counter <= latch;
          else
            en <= 1'b0;
        end else begin
          counter <= counter - 16'd1;
        end
      end

      // Register writes come last so a THI or CTRL write overrides the same-edge tick
      if (wr) begin
        case (offset)
          3'd0: latch[7:0] <= DO;
          3'd1: begin
            latch[15:8] <= DO;
            counter     <= {DO, latch[7:0]};
            prescaler   <= pre;
            en          <= 1'b1;
            tf          <= 1'b0;
          end
          3'd2: {ie, cont, en} <= DO[2:0];
          3'd3: if (DO[0] && !expire) tf <= 1'b0;
          3'd4: pre <= DO;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// tb/tb_bus_timer.sv - self-checking bench for bus_timer with arithmetic timer model
module tb_bus_timer;

  localparam logic [15:0] B = 16'hFE00;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] AD;
  logic [7:0]  DO;
  logic        WE;
  logic        RDY;
  logic [7:0]  DI;
  logic        hit;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_timer dut (
    .clk(clk), .RST(RST), .AD(AD), .DO(DO), .WE(WE), .RDY(RDY),
    .DI(DI), .hit(hit), .IRQ(IRQ)
  );

  task automatic step(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
    AD = a; DO = d; WE = w; RDY = r;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] off);
    step(B + {13'd0, off}, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    step(B + {13'd0, off}, d, 1'b1, 1'b1);
  endtask

  task automatic idle();
    step(16'h0000, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle();
    RST = 1'b0;
  endtask

  // Timer state e edges after the THI commit, from tick count n = e/(P+1)
  function automatic void model(input int l, input int p, input bit cont, input int e,
                                output int ctr, output bit tf, output bit en);
    int n;
    n = e / (p + 1);
    if (cont) begin
      ctr = l - (n % (l + 1));
      tf  = (n >= l + 1);
      en  = 1'b1;
    end else if (n <= l) begin
      ctr = l - n; tf = 1'b0; en = 1'b1;
    end else begin
      ctr = 0; tf = 1'b1; en = 1'b0;
    end
  endfunction

  task automatic test_reset();
    logic [7:0] exp;
    do_reset();
    checks++;
    if (DI !== 8'h00 || hit !== 1'b0 || IRQ !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: DI=%h hit=%b IRQ=%b expected 00 0 0", DI, hit, IRQ);
    end
    for (int i = 0; i < 8; i++) begin
      rd(3'(i));
      exp = (i < 2) ? 8'hFF : 8'h00;
      checks++;
      if (DI !== exp || hit !== 1'b1) begin
        errors++; $display("FAIL reset_read off=%0d: DI=%h hit=%b expected %h 1", i, DI, hit, exp);
      end
    end
    step(16'h1234, 8'h00, 1'b0, 1'b1);
    checks++;
    if (DI !== 8'h00 || hit !== 1'b0) begin
      errors++; $display("FAIL reset_miss: DI=%h hit=%b expected 00 0", DI, hit);
    end
  endtask

  task automatic test_cont();
    logic [7:0] exp;
    do_reset();
    wr(3'd4, 8'h00); wr(3'd0, 8'h03); wr(3'd2, 8'h06); wr(3'd1, 8'h00);
    for (int e = 1; e <= 12; e++) begin
      rd(3'd0);
      exp = 8'(3 - ((e - 1) % 4));
      checks++;
      if (DI !== exp) begin
        errors++; $display("FAIL cont_counter e=%0d: DI=%h expected %h", e, DI, exp);
      end
      checks++;
      if (IRQ !== (e >= 5)) begin
        errors++; $display("FAIL cont_irq e=%0d: IRQ=%b expected %b", e, IRQ, (e >= 5));
      end
    end
    rd(3'd3);
    checks++;
    if (DI !== 8'h01) begin
      errors++; $display("FAIL cont_tf: DI=%h expected 01", DI);
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    wr(3'd4, 8'h02); wr(3'd2, 8'h00); wr(3'd0, 8'h01); wr(3'd1, 8'h00);
    for (int e = 1; e <= 10; e++) begin
      rd(3'd3);
      checks++;
      if (DI !== {7'd0, (e >= 7)} || IRQ !== 1'b0) begin
        errors++; $display("FAIL oneshot_tf e=%0d: DI=%h IRQ=%b expected %h 0", e, DI, IRQ, {7'd0, (e >= 7)});
      end
    end
    rd(3'd0);
    checks++;
    if (DI !== 8'h00) begin
      errors++; $display("FAIL oneshot_counter: DI=%h expected 00", DI);
    end
    rd(3'd2);
    checks++;
    if (DI !== 8'h00) begin
      errors++; $display("FAIL oneshot_ctrl: DI=%h expected 00", DI);
    end
  endtask

  task automatic test_snapshot();
    do_reset();
    wr(3'd4, 8'h03); wr(3'd2, 8'h00); wr(3'd0, 8'h00); wr(3'd1, 8'h01);
    rd(3'd0);
    checks++;
    if (DI !== 8'h00) begin
      errors++; $display("FAIL snap_low: DI=%h expected 00", DI);
    end
    for (int i = 0; i < 4; i++) idle();
    rd(3'd1);
    checks++;
    if (DI !== 8'h01) begin
      errors++; $display("FAIL snap_high: DI=%h expected 01", DI);
    end
    rd(3'd0);
    checks++;
    if (DI !== 8'hFF) begin
      errors++; $display("FAIL snap_after: DI=%h expected ff", DI);
    end
  endtask

  task automatic test_stat_collision();
    do_reset();
    wr(3'd4, 8'h00); wr(3'd0, 8'h03); wr(3'd2, 8'h06); wr(3'd1, 8'h00);
    idle(); idle(); idle();
    wr(3'd3, 8'h01);
    rd(3'd3);
    checks++;
    if (DI !== 8'h01) begin
      errors++; $display("FAIL stat_set_wins: DI=%h expected 01", DI);
    end
    wr(3'd3, 8'h01);
    checks++;
    if (IRQ !== 1'b1) begin
      errors++; $display("FAIL stat_irq_before: IRQ=%b expected 1", IRQ);
    end
    rd(3'd3);
    checks++;
    if (DI !== 8'h00 || IRQ !== 1'b0) begin
      errors++; $display("FAIL stat_clear: DI=%h IRQ=%b expected 00 0", DI, IRQ);
    end
  endtask

  task automatic test_thi_collision();
    do_reset();
    wr(3'd0, 8'h05);
    step(B + 16'd1, 8'h00, 1'b1, 1'b0);
    rd(3'd2);
    checks++;
    if (DI !== 8'h00) begin
      errors++; $display("FAIL rdy_low_ctrl: DI=%h expected 00", DI);
    end
    rd(3'd0);
    checks++;
    if (DI !== 8'hFF) begin
      errors++; $display("FAIL rdy_low_counter: DI=%h expected ff", DI);
    end
    wr(3'd4, 8'h00); wr(3'd2, 8'h00); wr(3'd0, 8'h01); wr(3'd1, 8'h00);
    idle();
    wr(3'd1, 8'h00);
    rd(3'd3);
    checks++;
    if (DI !== 8'h00) begin
      errors++; $display("FAIL thi_wins_tf: DI=%h expected 00", DI);
    end
    rd(3'd0);
    checks++;
    if (DI !== 8'h00) begin
      errors++; $display("FAIL thi_wins_counter: DI=%h expected 00", DI);
    end
  endtask

  task automatic test_pause();
    do_reset();
    wr(3'd4, 8'h00); wr(3'd0, 8'h10); wr(3'd2, 8'h00); wr(3'd1, 8'h00);
    idle(); idle();
    wr(3'd2, 8'h00);
    for (int i = 0; i < 5; i++) idle();
    rd(3'd0);
    checks++;
    if (DI !== 8'h0D) begin
      errors++; $display("FAIL pause_hold: DI=%h expected 0d", DI);
    end
    wr(3'd2, 8'h01);
    idle();
    rd(3'd0);
    checks++;
    if (DI !== 8'h0C) begin
      errors++; $display("FAIL pause_resume: DI=%h expected 0c", DI);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    do_reset();
    wr(3'd4, 8'h00); wr(3'd0, 8'h02); wr(3'd2, 8'h06); wr(3'd1, 8'h00);
    for (int i = 0; i < 8; i++) idle();
    checks++;
    if (IRQ !== 1'b1) begin
      errors++; $display("FAIL midreset_irq_before: IRQ=%b expected 1", IRQ);
    end
    RST = 1'b1;
    step(B + 16'd3, 8'h01, 1'b1, 1'b1);
    RST = 1'b0;
    checks++;
    if (DI !== 8'h00 || hit !== 1'b0 || IRQ !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: DI=%h hit=%b IRQ=%b expected 00 0 0", DI, hit, IRQ);
    end
    for (int i = 0; i < 6; i++) begin
      rd(3'(i % 5));
      exp = ((i % 5) < 2) ? 8'hFF : 8'h00;
      checks++;
      if (DI !== exp || IRQ !== 1'b0) begin
        errors++; $display("FAIL midreset_read off=%0d: DI=%h IRQ=%b expected %h 0", i % 5, DI, IRQ, exp);
      end
    end
  endtask

  task automatic test_random();
    int l, p, ctr, op;
    bit cont, ie, tf, en;
    logic [7:0] exp, snap_m;
    logic       exp_hit;
    logic [15:0] a;
    for (int t = 0; t < 8; t++) begin
      do_reset();
      l = $urandom_range(0, 12);
      if ($urandom_range(0, 3) == 0) l += 256;
      p = $urandom_range(0, 3);
      cont = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      snap_m = 8'h00;
      wr(3'd4, 8'(p)); wr(3'd0, 8'(l)); wr(3'd2, {5'd0, ie, cont, 1'b0}); wr(3'd1, 8'(l >> 8));
      for (int e = 1; e <= 40; e++) begin
        model(l, p, cont, e - 1, ctr, tf, en);
        op = $urandom_range(0, 4);
        exp_hit = 1'b1;
        case (op)
          0: begin rd(3'd0); exp = 8'(ctr); snap_m = 8'(ctr >> 8); end
          1: begin rd(3'd1); exp = snap_m; end
          2: begin rd(3'd2); exp = {5'd0, ie, cont, en}; end
          3: begin rd(3'd3); exp = {7'd0, tf}; end
          default: begin
            a = 16'($urandom);
            if (a[15:3] == B[15:3]) a[15] = ~a[15];
            step(a, 8'h00, 1'b0, 1'b1);
            exp = 8'h00; exp_hit = 1'b0;
          end
        endcase
        checks++;
        if (DI !== exp || hit !== exp_hit || IRQ !== (tf & ie)) begin
          errors++;
          $display("FAIL random t=%0d e=%0d op=%0d: DI=%h hit=%b IRQ=%b expected %h %b %b",
                   t, e, op, DI, hit, IRQ, exp, exp_hit, tf & ie);
        end
      end
    end
  endtask

  initial begin
    RST = 1'b0; AD = 16'h0000; DO = 8'h00; WE = 1'b0; RDY = 1'b1;
    test_reset();
    test_cont();
    test_oneshot();
    test_snapshot();
    test_stat_collision();
    test_thi_collision();
    test_pause();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
